// File: rtl/bpu_resolve.sv
// Branch resolution: queues IF predictions, checks them against EX outcomes,
// drives BHT updates, the fetch redirect handshake and prediction statistics.
//
// state | meaning
// IDLE  | normal operation, pops allowed
// REDIR | redirect pending, EX stalled, pushes dropped
module bpu_resolve #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pred_push,
  input  logic [31:0]      pred_pc,
  input  logic             pred_taken,
  output logic             pred_ready,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [31:0]      ex_pc,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic [31:0]      ex_fallthrough,
  output logic             ex_stall,
  input  logic             flush,
  output logic             update_en,
  output logic             taken,
  output logic [31:0]      pc_ex,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ready,
  output logic             sync_err,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, REDIR} state_t;

  state_t           state_q;
  logic [31:0]      mem_pc_q [DEPTH];
  logic [DEPTH-1:0] mem_t_q;
  logic [AW:0]      wr_q, rd_q;
  logic             update_en_q, taken_q, redirect_valid_q, sync_err_q;
  logic [31:0]      pc_ex_q, redirect_pc_q;
  logic [CNT_W-1:0] branch_cnt_q, mispred_cnt_q;

  logic        empty, full, in_redir, pop, pop_real, push_ok;
  logic        head_t, actual, mis, pc_mis, bad;
  logic [31:0] head_pc;

  always_comb begin
    empty    = (wr_q == rd_q);
    full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    in_redir = (state_q == REDIR);
    pop      = ex_valid && !in_redir && !flush;
    head_pc  = mem_pc_q[rd_q[AW-1:0]];
    // An empty FIFO has no prediction to offer: treat it as not-taken.
    head_t   = empty ? 1'b0 : mem_t_q[rd_q[AW-1:0]];
    actual   = ex_is_branch && ex_taken;
    mis      = (head_t != actual);
    pc_mis   = empty || (head_pc != ex_pc);
    bad      = pop && (mis || pc_mis);
    pop_real = pop && !empty && !bad;
    push_ok  = pred_push && !in_redir && !flush && !bad && (!full || pop_real);
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_pc_q[wr_q[AW-1:0]] <= pred_pc;
      mem_t_q[wr_q[AW-1:0]]  <= pred_taken;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      wr_q             <= '0;
      rd_q             <= '0;
      update_en_q      <= 1'b0;
      taken_q          <= 1'b0;
      pc_ex_q          <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      sync_err_q       <= 1'b0;
      branch_cnt_q     <= '0;
      mispred_cnt_q    <= '0;
    end else begin
      update_en_q <= pop && ex_is_branch;
      if (pop) begin
        taken_q <= ex_taken;
        pc_ex_q <= ex_pc;
        if (ex_is_branch) branch_cnt_q <= branch_cnt_q + CNT_W'(1);
        if (mis || pc_mis) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
        if (pc_mis) sync_err_q <= 1'b1;
      end
      if (flush) begin
        state_q          <= IDLE;
        redirect_valid_q <= 1'b0;
        wr_q             <= '0;
        rd_q             <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bad) begin
              state_q          <= REDIR;
              redirect_valid_q <= 1'b1;
              redirect_pc_q    <= actual ? ex_target : ex_fallthrough;
              wr_q             <= '0;
              rd_q             <= '0;
            end else begin
              wr_q <= wr_q + {{AW{1'b0}}, push_ok};
              rd_q <= rd_q + {{AW{1'b0}}, pop_real};
            end
          end
          REDIR: begin
            // Anything that slipped in during the redirect is wrong-path.
            if (redirect_ready) begin
              state_q          <= IDLE;
              redirect_valid_q <= 1'b0;
              wr_q             <= '0;
              rd_q             <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign pred_ready     = !full;
  assign ex_stall       = in_redir;
  assign update_en      = update_en_q;
  assign taken          = taken_q;
  assign pc_ex          = pc_ex_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign sync_err       = sync_err_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispred_cnt    = mispred_cnt_q;
endmodule
